// File: rtl/decode.sv
// RV32I decode stage: decodes the fetch strobe (or the held skid entry) into an
// output register toward execute, with a one-entry skid for the in-flight strobe.
module decode #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_en,
  input  logic          i_inst_valid,
  input  logic [31:0]   i_inst,
  input  logic [AW-1:0] i_pc,
  input  logic          i_flush,
  input  logic          i_ready,
  output logic          o_busy,
  output logic          o_valid,
  output logic [AW-1:0] o_pc,
  output logic [3:0]    o_op,
  output logic [4:0]    o_rd,
  output logic [4:0]    o_rs1,
  output logic [4:0]    o_rs2,
  output logic          o_rd_we,
  output logic [2:0]    o_funct3,
  output logic          o_alt,
  output logic [31:0]   o_imm,
  output logic          o_illegal,
  output logic          o_overrun
);
  localparam logic [3:0] OP_LUI = 4'd0, OP_AUIPC = 4'd1, OP_JAL = 4'd2, OP_JALR = 4'd3,
                         OP_BRANCH = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_OPIMM = 4'd7,
                         OP_OP = 4'd8, OP_FENCE = 4'd9, OP_SYSTEM = 4'd10, OP_ILL = 4'd15;

  logic          skid_full;
  logic [31:0]   skid_inst;
  logic [AW-1:0] skid_pc;

  // Skid entry is always older than the incoming strobe, so it decodes first.
  logic [31:0]   src_inst;
  logic [AW-1:0] src_pc;
  assign src_inst = skid_full ? skid_inst : i_inst;
  assign src_pc   = skid_full ? skid_pc : i_pc;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [3:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_rd_we;
  assign f3 = src_inst[14:12];
  assign f7 = src_inst[31:25];

  always_comb begin
    dec_op = OP_ILL;
    if (src_inst[1:0] == 2'b11) begin
      case (src_inst[6:2])
        5'b01101: dec_op = OP_LUI;
        5'b00101: dec_op = OP_AUIPC;
        5'b11011: dec_op = OP_JAL;
        5'b11001: if (f3 == 3'b000) dec_op = OP_JALR;
        5'b11000: if (f3 != 3'b010 && f3 != 3'b011) dec_op = OP_BRANCH;
        5'b00000: if (f3 != 3'b011 && f3 < 3'b110) dec_op = OP_LOAD;
        5'b01000: if (f3 < 3'b011) dec_op = OP_STORE;
        5'b00100: begin
          if (f3 == 3'b001) begin
            if (f7 == 7'd0) dec_op = OP_OPIMM;
          end else if (f3 == 3'b101) begin
            if (f7 == 7'd0 || f7 == 7'b0100000) dec_op = OP_OPIMM;
          end else begin
            dec_op = OP_OPIMM;
          end
        end
        5'b01100: if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    dec_op = OP_OP;
        5'b00011: dec_op = OP_FENCE;
        5'b11100: if (src_inst == 32'h0000_0073 || src_inst == 32'h0010_0073) dec_op = OP_SYSTEM;
        default:  dec_op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    dec_imm   = 32'd0;
    dec_rd_we = 1'b0;
    case (dec_op)
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM:
        dec_imm = {{20{src_inst[31]}}, src_inst[31:20]};
      OP_STORE:
        dec_imm = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
      OP_BRANCH:
        dec_imm = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25],
                   src_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        dec_imm = {src_inst[31:12], 12'd0};
      OP_JAL:
        dec_imm = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20],
                   src_inst[30:21], 1'b0};
      default: dec_imm = 32'd0;
    endcase
    case (dec_op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP:
        dec_rd_we = (src_inst[11:7] != 5'd0);
      default: dec_rd_we = 1'b0;
    endcase
  end

  // Handshake: a transfer to execute happens on an enabled edge where o_valid and
  // i_ready are both high; o_valid and fields stay stable while i_ready is low.
  logic out_free;
  logic load_out;
  assign out_free = !o_valid || i_ready;
  assign load_out = out_free && (skid_full || i_inst_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      skid_full <= 1'b0;
      skid_inst <= 32'd0;
      skid_pc   <= '0;
      o_overrun <= 1'b0;
      o_pc      <= '0;
      o_op      <= 4'd0;
      o_rd      <= 5'd0;
      o_rs1     <= 5'd0;
      o_rs2     <= 5'd0;
      o_rd_we   <= 1'b0;
      o_funct3  <= 3'd0;
      o_alt     <= 1'b0;
      o_imm     <= 32'd0;
      o_illegal <= 1'b0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        o_valid   <= 1'b0;
        skid_full <= 1'b0;
      end else if (out_free) begin
        o_valid <= skid_full || i_inst_valid;
        if (skid_full) begin
          skid_full <= i_inst_valid;
          if (i_inst_valid) begin
            skid_inst <= i_inst;
            skid_pc   <= i_pc;
          end
        end
      end else if (i_inst_valid) begin
        if (skid_full) begin
          o_overrun <= 1'b1;
        end else begin
          skid_full <= 1'b1;
          skid_inst <= i_inst;
          skid_pc   <= i_pc;
        end
      end
      if (!i_flush && load_out) begin
        o_pc      <= src_pc;
        o_op      <= dec_op;
        o_rd      <= src_inst[11:7];
        o_rs1     <= src_inst[19:15];
        o_rs2     <= src_inst[24:20];
        o_rd_we   <= dec_rd_we;
        o_funct3  <= f3;
        o_alt     <= src_inst[30];
        o_imm     <= dec_imm;
        o_illegal <= (dec_op == OP_ILL);
      end
    end
  end

  assign o_busy = skid_full;
endmodule
